// File: rtl/i2c_pkg.sv
// Shared definitions for the multi-byte I2C master: FSM state encoding,
// quarter-period phase encoding and the R/W bit values carried in the
// address byte.
package i2c_pkg;

  // Controller states; RSTART only exists when repeated start is built in.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WRITE     = 4'd4,
    ST_WRITE_ACK = 4'd5,
`ifdef I2C_REPEATED_START_EN
    ST_RSTART    = 4'd6,
`endif
    ST_READ      = 4'd7,
    ST_MACK      = 4'd8,
    ST_STOP      = 4'd9,
    ST_DONE      = 4'd10
  } i2c_state_e;

  // Four quarters of one bit cell: SCL low, low, high, high.
  typedef enum logic [1:0] {
    PH_LOW0  = 2'd0,
    PH_LOW1  = 2'd1,
    PH_HIGH0 = 2'd2,
    PH_HIGH1 = 2'd3
  } i2c_phase_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period tick and phase generator for the I2C bit cell.
// While run is low the counter and phase are held at zero, so every
// bit cell begins at PH_LOW0 the cycle run rises.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       tick,
  output i2c_phase_e phase
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CNT_MAX);

  // Count clk cycles inside a quarter and step the phase at each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= PH_LOW0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= PH_LOW0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= i2c_phase_e'(phase + 2'd1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_multi.sv
// Multi-byte I2C master: START, 7-bit address + R/W, up to 2^LEN_W-1
// write bytes and/or read bytes, master ACK/NACK, STOP.
// Optional feature macro: I2C_REPEATED_START_EN -- when defined, a read
// request with wr_len>0 first writes wr_len bytes, then issues a repeated
// start and the address with R=1 before reading.
//
// Handshakes: start is a one-cycle request taken only while busy=0;
// tx_data must stay stable until the cycle tx_ready pulses (that is the
// cycle after it was latched), rx_data is valid in the cycle rx_valid
// pulses, done pulses once after STOP with busy still high, and busy
// drops the following cycle.
//
// SCL and SDA are registered; SDA is delayed one extra clk behind SCL so
// data changes land clearly after the SCL falling edge. CLK_DIV >= 2 keeps
// that extra cycle inside a single quarter.
module i2c_master_multi
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [LEN_W-1:0] rd_len,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             i2c_sclk,
  inout  wire              i2c_sdat,
  output i2c_state_e       state_dbg
);

  i2c_state_e       state, state_nx;
  i2c_phase_e       phase;
  logic             tick, run, bit_end, samp;
  logic [6:0]       addr_q;
  logic             reading_q;
  logic [LEN_W-1:0] wr_cnt, rd_cnt;
  logic [7:0]       sh;
  logic [2:0]       bit_cnt;
  logic             ack_q;
  logic             scl_d, sda_oe_d;
  logic             scl_q, sda_oe_p, sda_oe_q;
  logic             sda_in;
`ifdef I2C_REPEATED_START_EN
  logic             rw_q;
`endif

  assign run     = (state != ST_IDLE) && (state != ST_DONE);
  assign bit_end = tick && (phase == PH_HIGH1);
  assign samp    = tick && (phase == PH_HIGH0);
  assign sda_in  = i2c_sdat;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;
  assign i2c_sclk  = scl_q;
  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick),
    .phase (phase)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and bus-line decode; sda_oe_d=1 pulls SDA low.
  always_comb begin
    state_nx = state;
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_START;
      end
      ST_START: begin
        sda_oe_d = phase[1];
        if (bit_end) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        scl_d    = phase[1];
        sda_oe_d = ~sh[7];
        if (bit_end && (bit_cnt == 3'd0)) state_nx = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        scl_d = phase[1];
        if (bit_end) begin
          if (ack_q)               state_nx = ST_STOP;
          else if (reading_q)      state_nx = ST_READ;
          else if (wr_cnt != '0)   state_nx = ST_WRITE;
          else                     state_nx = ST_STOP;
        end
      end
      ST_WRITE: begin
        scl_d    = phase[1];
        sda_oe_d = ~sh[7];
        if (bit_end && (bit_cnt == 3'd0)) state_nx = ST_WRITE_ACK;
      end
      ST_WRITE_ACK: begin
        scl_d = phase[1];
        if (bit_end) begin
          if (ack_q)             state_nx = ST_STOP;
          else if (wr_cnt != '0) state_nx = ST_WRITE;
`ifdef I2C_REPEATED_START_EN
          else if (rw_q)         state_nx = ST_RSTART;
`endif
          else                   state_nx = ST_STOP;
        end
      end
`ifdef I2C_REPEATED_START_EN
      ST_RSTART: begin
        scl_d    = (phase != PH_LOW0);
        sda_oe_d = (phase == PH_HIGH1);
        if (bit_end) state_nx = ST_ADDR;
      end
`endif
      ST_READ: begin
        scl_d = phase[1];
        if (bit_end && (bit_cnt == 3'd0)) state_nx = ST_MACK;
      end
      ST_MACK: begin
        scl_d    = phase[1];
        sda_oe_d = (rd_cnt != '0);
        if (bit_end) state_nx = (rd_cnt != '0) ? ST_READ : ST_STOP;
      end
      ST_STOP: begin
        scl_d    = (phase != PH_LOW0);
        sda_oe_d = (phase != PH_HIGH1);
        if (bit_end) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Registered bus lines; SDA trails SCL by one extra clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q    <= 1'b1;
      sda_oe_p <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      scl_q    <= scl_d;
      sda_oe_p <= sda_oe_d;
      sda_oe_q <= sda_oe_p;
    end
  end

  // Request latch, shifter, byte counters and handshake strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      reading_q <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      ack_q     <= 1'b0;
      nack      <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
`ifdef I2C_REPEATED_START_EN
      rw_q      <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= dev_addr;
            nack   <= 1'b0;
            rd_cnt <= (rd_len == '0) ? LEN_W'(1) : rd_len;
`ifdef I2C_REPEATED_START_EN
            rw_q      <= rw;
            reading_q <= rw && (wr_len == '0);
            wr_cnt    <= wr_len;
`else
            reading_q <= rw;
            wr_cnt    <= rw ? '0 : wr_len;
`endif
          end
        end
`ifdef I2C_REPEATED_START_EN
        ST_START, ST_RSTART: begin
`else
        ST_START: begin
`endif
          if (bit_end) begin
            sh      <= {addr_q, reading_q ? RW_READ : RW_WRITE};
            bit_cnt <= 3'd7;
          end
        end
        ST_ADDR, ST_WRITE: begin
          if (bit_end && (bit_cnt != 3'd0)) begin
            sh      <= {sh[6:0], 1'b1};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          if (samp) ack_q <= sda_in;
          if (bit_end) begin
            if (ack_q) nack <= 1'b1;
            if (state_nx == ST_WRITE) begin
              sh       <= tx_data;
              tx_ready <= 1'b1;
              wr_cnt   <= wr_cnt - LEN_W'(1);
              bit_cnt  <= 3'd7;
            end
            if (state_nx == ST_READ) bit_cnt <= 3'd7;
`ifdef I2C_REPEATED_START_EN
            if (state_nx == ST_RSTART) reading_q <= 1'b1;
`endif
          end
        end
        ST_READ: begin
          if (samp) begin
            sh <= {sh[6:0], sda_in};
            if (bit_cnt == 3'd0) begin
              rx_data  <= {sh[6:0], sda_in};
              rx_valid <= 1'b1;
            end
          end
          if (bit_end) begin
            if (bit_cnt != 3'd0)    bit_cnt <= bit_cnt - 3'd1;
            else if (rd_cnt != '0)  rd_cnt  <= rd_cnt - LEN_W'(1);
          end
        end
        ST_MACK: begin
          if (bit_end && (state_nx == ST_READ)) bit_cnt <= 3'd7;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_multi.sv
// Directed bench for i2c_master_multi with a behavioural I2C slave that
// ACKs every address except 0x2B, logs master-sent bytes and master
// ACK/NACK bits, and serves read bytes from a queue.
module tb_i2c_master_multi;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;
  localparam int TMO     = 20000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       dev_addr = '0;
  logic [LEN_W-1:0] wr_len = '0;
  logic [LEN_W-1:0] rd_len = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid, busy, done, nack, scl;
  wire              sda_bus;
  i2c_state_e       state_dbg;
  logic             slave_oe = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_oe ? 1'b0 : 1'bz;

  i2c_master_multi #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .wr_len(wr_len), .rd_len(rd_len), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .nack(nack), .i2c_sclk(scl), .i2c_sdat(sda_bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rx[$];
  logic       exp_mack[$];
  logic [7:0] bus_log[$];
  logic [7:0] rx_log[$];
  logic       mack_log[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] rd_bytes[$];
  int         rise_cyc[$];
  int n_txr = 0, n_done = 0, n_start = 0, n_stop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         bit_idx = 0;
  logic [7:0] shreg = '0, cur_byte = '0;
  logic       in_addr = 1'b1, rd_mode = 1'b0, addr_nack = 1'b0;

  always @(scl or sda_bus) begin
    if (scl === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b1 && sda_bus === 1'b0) begin
      n_start++; bit_idx = 0; in_addr = 1'b1; rd_mode = 1'b0; addr_nack = 1'b0; slave_oe = 1'b0;
    end else if (scl === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b0 && sda_bus === 1'b1) begin
      n_stop++; bit_idx = 0; in_addr = 1'b1; rd_mode = 1'b0; slave_oe = 1'b0;
    end else if (scl_prev === 1'b0 && scl === 1'b1) begin
      rise_cyc.push_back(cyc);
      if (bit_idx < 8) begin
        shreg = {shreg[6:0], sda_bus};
        bit_idx++;
        if (bit_idx == 8 && !(rd_mode && !in_addr)) begin
          bus_log.push_back(shreg);
          if (in_addr) begin
            rd_mode   = shreg[0];
            addr_nack = (shreg[7:1] == 7'h2B);
          end
        end
      end else begin
        if (rd_mode && !in_addr) begin
          mack_log.push_back(sda_bus);
          if (sda_bus === 1'b1) rd_mode = 1'b0;
        end
        bit_idx = 0;
        in_addr = 1'b0;
      end
    end else if (scl_prev === 1'b1 && scl === 1'b0) begin
      if (bit_idx == 8) begin
        if (rd_mode && !in_addr) slave_oe = 1'b0;
        else slave_oe = !(in_addr && addr_nack);
      end else if (rd_mode && !in_addr) begin
        if (bit_idx == 0) cur_byte = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hFF;
        slave_oe = ~cur_byte[7-bit_idx];
      end else begin
        slave_oe = 1'b0;
      end
    end
    scl_prev = scl;
    sda_prev = sda_bus;
  end

  // Pulse monitor and tx_data driver: next byte presented after each tx_ready.
  always @(negedge clk) begin
    if (tx_ready === 1'b1) begin
      n_txr++;
      if (tx_bytes.size() > 0) tx_data = tx_bytes.pop_front();
    end
    if (rx_valid === 1'b1) rx_log.push_back(rx_data);
    if (done === 1'b1) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    bus_log.delete(); rx_log.delete(); mack_log.delete(); rise_cyc.delete();
    n_txr = 0; n_done = 0; n_start = 0; n_stop = 0;
  endtask

  task automatic kick(input logic r, input logic [6:0] a, input logic [LEN_W-1:0] wl,
                      input logic [LEN_W-1:0] rl);
    @(negedge clk);
    rw = r; dev_addr = a; wr_len = wl; rd_len = rl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble request inputs: the DUT must have latched them
    rw = ~r; dev_addr = 7'h7F; wr_len = '1; rd_len = '1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, 32'(n < TMO), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_nbytes"}, bus_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < bus_log.size()) ? 32'(bus_log[i]) : 32'hDEAD,
            32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_nrx"}, rx_log.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size(); i++)
      check($sformatf("%s_rx%0d", tag, i), (i < rx_log.size()) ? 32'(rx_log[i]) : 32'hDEAD,
            32'(exp_rx[i]));
    check({tag, "_nmack"}, mack_log.size(), exp_mack.size());
    for (int i = 0; i < exp_mack.size(); i++)
      check($sformatf("%s_mack%0d", tag, i), (i < mack_log.size()) ? 32'(mack_log[i]) : 32'hDEAD,
            32'(exp_mack[i]));
    exp_rx.delete(); exp_mack.delete();
  endtask

  task automatic slave_reset();
    bit_idx = 0; in_addr = 1'b1; rd_mode = 1'b0; addr_nack = 1'b0; slave_oe = 1'b0;
    rd_bytes.delete(); tx_bytes.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (4) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_bus, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_txr", tx_ready, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();

    // Write 2 bytes to 0x1A; a start mid-transfer must be ignored.
    tx_data = 8'h34; tx_bytes.push_back(8'h56);
    kick(1'b0, 7'h1A, 4'd2, 4'd0);
    check("wr_busy", busy, 1);
    repeat (60) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("wr");
    repeat (200) @(negedge clk);
    exp_q.push_back(8'h34); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    check_bus("wr");
    check("wr_txr", n_txr, 2);
    check("wr_ndone", n_done, 1);
    check("wr_nack", nack, 0);
    check("wr_nstart", n_start, 1);
    check("wr_nstop", n_stop, 1);
    check("wr_busy_end", busy, 0);
    check("scl_period", (rise_cyc.size() > 3) ? 32'(rise_cyc[2] - rise_cyc[1]) : 32'hDEAD,
          32'(4 * CLK_DIV));
    clear_logs();

    // Read 3 bytes from 0x1A.
    rd_bytes.push_back(8'hA5); rd_bytes.push_back(8'h5A); rd_bytes.push_back(8'hFF);
    kick(1'b1, 7'h1A, 4'd0, 4'd3);
    wait_done("rd");
    exp_q.push_back(8'h35);
    check_bus("rd");
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h5A); exp_rx.push_back(8'hFF);
    exp_mack.push_back(1'b0); exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
    check_rx("rd");
    check("rd_rxdata", rx_data, 8'hFF);
    check("rd_nstop", n_stop, 1);
    check("rd_nack", nack, 0);
    clear_logs();

    // Address NACK on 0x2B, then an address-only probe clears nack.
    tx_data = 8'h77;
    kick(1'b0, 7'h2B, 4'd1, 4'd0);
    wait_done("nk");
    check("nk_nack", nack, 1);
    exp_q.push_back(8'h56);
    check_bus("nk");
    check("nk_txr", n_txr, 0);
    check("nk_nstop", n_stop, 1);
    check("nk_ndone", n_done, 1);
    repeat (20) @(negedge clk);
    check("nk_sticky", nack, 1);
    clear_logs();
    kick(1'b0, 7'h1A, 4'd0, 4'd0);
    check("nk_cleared", nack, 0);
    wait_done("probe");
    exp_q.push_back(8'h34);
    check_bus("probe");
    check("probe_nack", nack, 0);
    check("probe_nstop", n_stop, 1);
    clear_logs();

    // Read request with wr_len=1 (0x10), rd_len=1.
    tx_data = 8'h10; rd_bytes.push_back(8'hC3);
    kick(1'b1, 7'h1A, 4'd1, 4'd1);
    wait_done("wrd");
`ifdef I2C_REPEATED_START_EN
    exp_q.push_back(8'h34); exp_q.push_back(8'h10); exp_q.push_back(8'h35);
    check_bus("wrd");
    check("wrd_nstart", n_start, 2);
    check("wrd_txr", n_txr, 1);
`else
    exp_q.push_back(8'h35);
    check_bus("wrd");
    check("wrd_nstart", n_start, 1);
    check("wrd_txr", n_txr, 0);
`endif
    exp_rx.push_back(8'hC3); exp_mack.push_back(1'b1);
    check_rx("wrd");
    check("wrd_nstop", n_stop, 1);
    clear_logs();

    // rd_len=0 reads exactly one byte.
    rd_bytes.push_back(8'h3C);
    kick(1'b1, 7'h1A, 4'd0, 4'd0);
    wait_done("rd0");
    exp_rx.push_back(8'h3C); exp_mack.push_back(1'b1);
    check_rx("rd0");
    clear_logs();

    // Reset in the middle of the second byte of a write.
    tx_data = 8'h34; tx_bytes.push_back(8'h56);
    kick(1'b0, 7'h1A, 4'd2, 4'd0);
    n = 0;
    while (!(bus_log.size() == 2 && bit_idx == 4) && n < TMO) begin @(negedge clk); n++; end
    check("mid_reach", 32'(n < TMO), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_scl", scl, 1);
    check("mid_sda", sda_bus, 1);
    check("mid_busy", busy, 0);
    check("mid_state", state_dbg, ST_IDLE);
    check("mid_ndone", n_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    slave_reset();
    repeat (3) @(negedge clk);
    clear_logs();
    tx_data = 8'h9E;
    kick(1'b0, 7'h1A, 4'd1, 4'd0);
    wait_done("post");
    exp_q.push_back(8'h34); exp_q.push_back(8'h9E);
    check_bus("post");
    check("post_txr", n_txr, 1);
    check("post_nack", nack, 0);
    check("post_ndone", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_multi.md
I2C_MASTER_MULTI -- requirements
Module: i2c_master_multi

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125, giving the number of clk cycles per SCL quarter-period (50 MHz clk -> 100 kHz SCL).
REQ-002 The block SHALL have parameter LEN_W, default 4, giving the width of the byte-count fields (0..2^LEN_W-1 bytes).
REQ-003 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request; SHALL be sampled only when busy=0.
REQ-006 rw  in  1  direction: 0 = write, 1 = read.
REQ-007 dev_addr  in  7  target slave address.
REQ-008 wr_len  in  LEN_W  number of bytes to write.
REQ-009 rd_len  in  LEN_W  number of bytes to read.
REQ-010 tx_data  in  8  next write byte; SHALL be held stable until tx_ready.
REQ-011 tx_ready  out  1  one-cycle pulse when tx_data has been latched for shifting.
REQ-012 rx_data  out  8  last byte received.
REQ-013 rx_valid  out  1  one-cycle pulse when rx_data has been updated.
REQ-014 busy  out  1  high from the accepted start until done.
REQ-015 done  out  1  one-cycle pulse after STOP completes.
REQ-016 nack  out  1  sticky error flag for a slave NACK; SHALL be cleared by the next accepted start.
REQ-017 i2c_sclk  out  1  SCL line.
REQ-018 i2c_sdat  inout  1  open-drain SDA; SHALL be driven only 0 or Z.

Function
REQ-019 The controller SHALL use a quarter-period tick counter (0..CLK_DIV-1) with four phases per bit: SCL low/low/high/high; SDA SHALL change only in phase 0 and SHALL be sampled at the end of phase 2.
REQ-020 The FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, RSTART, READ, MACK, STOP, DONE.
REQ-021 On start in IDLE, the controller SHALL latch all request inputs, set busy the next cycle, and go to START.
REQ-022 In START, SDA SHALL fall while SCL is high, and the controller SHALL then go to ADDR.
REQ-023 In ADDR, the controller SHALL shift {dev_addr, R/W} MSB first, then go to ADDR_ACK.
REQ-024 If the slave answers NACK in ADDR_ACK or WRITE_ACK, the controller SHALL set nack and go to STOP.
REQ-025 Write bytes SHALL be shifted MSB first; tx_ready SHALL pulse at the first tick of each byte, and the controller SHALL go to WRITE_ACK after 8 bits.
REQ-026 The controller SHALL go to STOP after the last write byte, or after ADDR_ACK when wr_len=0 and rw=0 (address-only probe).
REQ-027 In READ, the controller SHALL release SDA and sample 8 bits, and SHALL pulse rx_valid on the 8th sample.
REQ-028 In MACK, the controller SHALL drive ACK (0) for every byte except the last and NACK (Z) for the last, then go to STOP.
REQ-029 A read with rd_len=0 SHALL be treated as rd_len=1.
REQ-030 In STOP, SDA SHALL rise while SCL is high; the controller SHALL then pulse done, clear busy, and return to IDLE.
REQ-031 start while busy=1 SHALL be ignored, with no queuing.
REQ-032 Byte counters SHALL be LEN_W bits wide and SHALL count down with no wrap-around.

Reset
REQ-033 While reset=0, the outputs SHALL be: i2c_sclk=1, i2c_sdat=Z, busy=0, done=0, nack=0, tx_ready=0, rx_valid=0, rx_data=0, FSM in IDLE, counters at 0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately with no STOP generated and the lines released.

Configuration
REQ-035 With I2C_REPEATED_START_EN defined, rw=1 with wr_len>0 SHALL run the write phase, then RSTART (SDA high, SCL high, SDA falls), then the address with R=1, then the read phase.
REQ-036 Without I2C_REPEATED_START_EN, wr_len SHALL be ignored when rw=1, and the RSTART state SHALL be absent.

Structure
REQ-037 The state enumeration, the phase encoding and the R/W bit constants SHALL be defined in a shared package i2c_pkg.
REQ-038 The SCL tick/phase generator SHALL be a sub-module named i2c_bit_timer, with outputs tick and phase[1:0].

Verification
REQ-039 Write 0x1A, wr_len=2, data 0x34, 0x56, slave ACKs -> bus carries 0x34, 0x34, 0x56; two tx_ready pulses; done; nack=0.
REQ-040 Read 0x1A, rd_len=3, slave returns 0xA5, 0x5A, 0xFF -> three rx_valid pulses with those values; master ACK, ACK, NACK; STOP.
REQ-041 Address NACK on 0x2B -> nack=1, STOP, done; the next start clears nack.
REQ-042 With I2C_REPEATED_START_EN: rw=1, wr_len=1 (0x10), rd_len=1 -> write 0x34, 0x10, Sr, 0x35, read 1 byte, STOP.
REQ-043 reset pulled low in bit 4 of the second byte -> lines released within 1 cycle of reset and busy=0; a new transfer succeeds.
REQ-044 CLK_DIV=4 -> each SCL period is exactly 16 clk cycles, and a start during busy is ignored.
